// File: rtl/ring_nic.sv
// NIC bridging the CPU register port to the local ring router port.
// Holds one injection FIFO (CPU to router) and one ejection FIFO (router to CPU).
module ring_nic #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [0:1]            nicAddr,
  input  logic [0:DATA_WIDTH-1] nicDataIn,
  output logic [0:DATA_WIDTH-1] nicDataOut,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [0:DATA_WIDTH-1] net_do,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [0:DATA_WIDTH-1] net_di
);

  // At least one index bit so DEPTH=1 still gets a legal slice; count bounds occupancy.
  localparam int         IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int         SLOTS    = 1 << IW;
  localparam logic [IW:0] FULL_CNT = (IW + 1)'(DEPTH);
  localparam logic [IW:0] ONE      = (IW + 1)'(1);

  logic [0:DATA_WIDTH-1] of_mem [SLOTS];
  logic [0:DATA_WIDTH-1] if_mem [SLOTS];

  logic [IW:0] of_wp, of_rp, of_cnt;
  logic [IW:0] if_wp, if_rp, if_cnt;

  logic of_full, of_empty, of_push, of_pop;
  logic if_full, if_empty, if_push, if_pop;
  logic [0:DATA_WIDTH-1] of_head, if_head;

  assign of_full  = (of_cnt == FULL_CNT);
  assign of_empty = (of_cnt == '0);
  assign if_full  = (if_cnt == FULL_CNT);
  assign if_empty = (if_cnt == '0);

  assign of_head = of_mem[of_rp[IW-1:0]];
  assign if_head = if_mem[if_rp[IW-1:0]];

  // Full is sampled before the same-cycle pop, so a write to a full FIFO drops.
  assign of_push = nicEn & nicWrEn & (nicAddr == 2'b10) & ~of_full;
  assign of_pop  = net_so;
  assign net_so  = ~of_empty & net_ro;
  assign net_do  = of_empty ? '0 : of_head;

  assign net_ri  = ~if_full;
  assign if_push = net_si & net_ri;
  assign if_pop  = nicEn & ~nicWrEn & (nicAddr == 2'b00) & ~if_empty;

  always_comb begin
    nicDataOut = '0;
    if (nicEn && !nicWrEn) begin
      case (nicAddr)
        2'b00:   if (!if_empty) nicDataOut = if_head;
        2'b01:   nicDataOut[DATA_WIDTH-1] = ~if_empty;
        2'b11:   nicDataOut[DATA_WIDTH-1] = of_full;
        default: nicDataOut = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      of_wp  <= '0;
      of_rp  <= '0;
      of_cnt <= '0;
      if_wp  <= '0;
      if_rp  <= '0;
      if_cnt <= '0;
    end else begin
      if (of_push) of_wp <= of_wp + ONE;
      if (of_pop)  of_rp <= of_rp + ONE;
      case ({of_push, of_pop})
        2'b10:   of_cnt <= of_cnt + ONE;
        2'b01:   of_cnt <= of_cnt - ONE;
        default: of_cnt <= of_cnt;
      endcase
      if (if_push) if_wp <= if_wp + ONE;
      if (if_pop)  if_rp <= if_rp + ONE;
      case ({if_push, if_pop})
        2'b10:   if_cnt <= if_cnt + ONE;
        2'b01:   if_cnt <= if_cnt - ONE;
        default: if_cnt <= if_cnt;
      endcase
    end
  end

  // Storage needs no reset: contents are only visible through a non-empty head.
  always_ff @(posedge clk) begin
    if (of_push) of_mem[of_wp[IW-1:0]] <= nicDataIn;
    if (if_push) if_mem[if_wp[IW-1:0]] <= net_di;
  end

endmodule

// File: doc/ring_nic.md
Name: ring_nic

Overview:
- Network interface controller at the CPU's NIC port: the responder to the processor's nicAddr/nicEn/nicWrEn/nicDataIn/nicDataOut accesses.
- Bridges the processor to the local router port of the bidirectional ring NoC.
- Holds one injection FIFO (CPU to network) and one ejection FIFO (network to CPU).
- Each FIFO has a status word the CPU polls through a 2-bit register address.

Parameters:
- DATA_WIDTH, 64, packet/word width; equals the CPU data width.
- DEPTH, 2, entries per FIFO; power of two, at least 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- nicAddr  input  [0:1]  register select: 00 ejection data, 01 ejection status, 10 injection data, 11 injection status.
- nicDataIn  input  [0:DATA_WIDTH-1]  CPU write data.
- nicDataOut  output  [0:DATA_WIDTH-1]  CPU read data.
- nicEn  input  1  access strobe.
- nicWrEn  input  1  1 = write, 0 = read; qualified by nicEn.
- net_so  output  1  send to router; a packet transfers on every rising edge where net_so=1.
- net_ro  input  1  router ready to accept a packet.
- net_do  output  [0:DATA_WIDTH-1]  packet to router.
- net_si  input  1  router sends a packet.
- net_ri  output  1  NIC ready to accept a packet.
- net_di  input  [0:DATA_WIDTH-1]  packet from router.

Behaviour:
- Reset (async, immediate):
  - Both FIFOs are emptied: read/write pointers and counts go to 0.
  - Outputs: net_so=0, net_ri=1, net_do=0, nicDataOut=0.
  - FIFO storage contents are don't-care and are never visible.
  - A transfer in flight at reset assertion is lost; no partial state survives.
- Injection FIFO (OF), CPU writes to the network:
  - CPU write = nicEn & nicWrEn & nicAddr==10.
  - If OF is not full, nicDataIn is pushed at the edge.
  - If OF is full, the write is silently dropped and no state changes. Software must poll status first.
  - net_do = OF head when not empty, else 0.
  - net_so = (OF not empty) & net_ro, combinational.
  - A pop occurs at each edge where net_so=1.
  - Push and pop in the same cycle: both happen and the count is unchanged. When OF is full, the full flag is sampled before the pop, so that push is dropped.
- Ejection FIFO (IF), network to the CPU:
  - net_ri = IF not full, combinational from state only (no dependence on net_si).
  - A push occurs at each edge where net_si & net_ri; net_di is captured.
  - net_si while net_ri=0 is a protocol violation by the router; the data is ignored.
  - CPU read = nicEn & ~nicWrEn & nicAddr==00.
  - The read returns the IF head combinationally in the same cycle and pops at the edge.
  - A read of an empty IF returns 0 and does not pop.
  - Simultaneous push and pop are allowed.
- Status reads:
  - Combinational, same cycle; status bit in nicDataOut[DATA_WIDTH-1], all other bits 0.
  - Address 01: 1 = IF not empty (packet waiting).
  - Address 11: 1 = OF full (do not write).
- Other accesses:
  - Writes to 00, 01 and 11 are ignored.
  - Reads of address 10 return 0.
  - nicDataOut=0 whenever nicEn=0 or nicWrEn=1.
- Pointers: log2(DEPTH) bits plus a wrap bit, wrapping modulo DEPTH. Full = count==DEPTH; empty = count==0.
- Latency:
  - CPU write to net_so: 1 cycle, assuming net_ro=1 and OF was empty.
  - net_si accept to status 01 reading 1: 1 cycle.
- Packet contents are not inspected or modified; the NIC is data-transparent.

Test Plan:
- Reset mid-traffic:
  - Stimulus: push 2 packets into OF with net_ro=0, then assert reset asynchronously between edges.
  - Required: net_so=0 immediately; status 11 reads 0; net_ri=1.
- Injection path:
  - Stimulus: net_ro=1, CPU writes 0x0123456789ABCDEF to addr 10.
  - Required: the next cycle has net_so=1 and net_do=0x0123456789ABCDEF for exactly 1 cycle, then net_so=0.
- Injection full/drop:
  - Stimulus: net_ro=0, write A, B, C to addr 10.
  - Required: status 11 reads 1 after B; C is dropped.
  - Stimulus: raise net_ro.
  - Required: net_do=A then B on consecutive cycles; no C.
- Ejection fill:
  - Stimulus: router sends X then Y with CPU idle.
  - Required: net_ri=0 after Y; status 01 reads 1.
  - Stimulus: read addr 00 twice.
  - Required: returns X, then Y; status 01 then reads 0 and net_ri=1.
- Simultaneous ejection push/pop:
  - Stimulus: IF holds 1 entry; CPU reads 00 in the same cycle net_si delivers Z.
  - Required: the read returns the old head; the count stays 1; the next read returns Z.
- Illegal/idle accesses:
  - Stimulus: read of empty 00, read of 10, write to 01.
  - Required: nicDataOut=0 and no status change.
